// File: rtl/fir_uart_pkg.sv
// Shared types and constants for the FIR output UART stage.
package fir_uart_pkg;

    localparam int FRAME_BITS       = 10;
    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/fir_uart_if.sv
// Valid/ready sample bundle from the FIR core into the UART stage.
interface fir_uart_if;
    import fir_uart_pkg::*;

    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/fir_uart_baud_cnt.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1, flags the last count.
module fir_uart_baud_cnt
    import fir_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fir_uart_tx.sv
// FIR sample -> UART 8N1 transmitter with one-entry holding register.
module fir_uart_tx
    import fir_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DROP_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    fir_uart_if.slave         s,
    input  logic              drop_clr,
    output logic              tx,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    state_e               state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shreg;
    logic                 hold_full;
    logic [2:0]           idx;
    logic                 bit_end;
    logic                 baud_en;
    logic                 baud_clr;
    logic                 accept;
    logic                 drop;
    logic                 load;

    assign s.s_ready = !hold_full;
    assign accept    = s.s_valid && !hold_full;
    assign drop      = s.s_valid && hold_full;
    assign busy      = (state != IDLE) || hold_full;
    assign baud_en   = (state != IDLE);
    assign baud_clr  = (state == IDLE);

    // Back-to-back frames: reload on the last stop-bit cycle.
    assign load = hold_full &&
                  ((state == IDLE) || ((state == STOP) && bit_end));

    fir_uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en     (baud_en),
        .clr    (baud_clr),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold      <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold      <= s.s_data;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            shreg <= '0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= hold;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (load) begin
                            shreg <= hold;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over the old value, but a same-cycle drop still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= drop ? DROP_W'(1) : '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_uart_tx.sv
// Directed bench for fir_uart_tx with CLKS_PER_BIT=4.
module tb_fir_uart_tx;
    import fir_uart_pkg::*;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       drop_clr;
    logic       tx;
    logic       busy;
    logic       tx4;
    logic       busy4;
    logic [7:0] drop8;
    logic [3:0] drop4;

    int n_cmp = 0;
    int n_err = 0;

    fir_uart_if sif ();
    fir_uart_if sif4 ();

    assign sif4.s_data  = sif.s_data;
    assign sif4.s_valid = sif.s_valid;

    fir_uart_tx #(.CLKS_PER_BIT(CPB), .DROP_W(8)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .s       (sif),
        .drop_clr(drop_clr),
        .tx      (tx),
        .busy    (busy),
        .drop_cnt(drop8)
    );

    fir_uart_tx #(.CLKS_PER_BIT(CPB), .DROP_W(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .s       (sif4),
        .drop_clr(drop_clr),
        .tx      (tx4),
        .busy    (busy4),
        .drop_cnt(drop4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic fbit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return d[i-1];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rl;
        int starts;
        logic prev;
        logic low_seen;

        rst         = 1'b1;
        drop_clr    = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;

        // 1: reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("t1_tx", tx, 1);
        chk("t1_ready", sif.s_ready, 1);
        chk("t1_busy", busy, 0);
        chk("t1_drop", drop8, 0);

        // 2: single frame 0xA5
        sif.s_valid = 1'b1;
        sif.s_data  = 8'hA5;
        tick();
        sif.s_valid = 1'b0;
        chk("t2_ready_acc", sif.s_ready, 0);
        chk("t2_tx_pre", tx, 1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("t2_c%0d", i), tx, fbit(8'hA5, i / 4));
        end
        chk("t2_busy_40", busy, 1);
        tick();
        chk("t2_busy_41", busy, 0);
        chk("t2_tx_idle", tx, 1);

        // 3: 0x00 then 0xFF queued mid-frame
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h00;
        tick();
        sif.s_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("t3a_c%0d", i), tx, fbit(8'h00, i / 4));
            if (i == 4) begin
                chk("t3_ready_pre", sif.s_ready, 1);
                sif.s_valid = 1'b1;
                sif.s_data  = 8'hFF;
            end
            if (i == 5) sif.s_valid = 1'b0;
            if (i >= 5) chk($sformatf("t3_rdy%0d", i), sif.s_ready, 0);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("t3b_c%0d", i), tx, fbit(8'hFF, i / 4));
            if (i == 0) chk("t3_ready_reload", sif.s_ready, 1);
        end
        tick();
        chk("t3_busy_end", busy, 0);

        // 4: continuous valid for 100 cycles
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        rl          = 0;
        starts      = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = 8'hFF;
        for (int i = 0; i < 100; i++) begin
            if (!sif.s_ready) rl++;
            prev = tx;
            tick();
            if (prev && !tx) starts++;
        end
        sif.s_valid = 1'b0;
        chk("t4_starts", starts, 3);
        chk("t4_ready_low", rl, 96);
        chk("t4_drop8", drop8, 96);
        chk("t4_drop4_sat", drop4, 15);
        for (int i = 0; i < 200 && busy; i++) tick();
        chk("t4_drain", busy, 0);

        // 5: reset during data bit 3
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h00;
        tick();
        sif.s_valid = 1'b0;
        repeat (17) tick();
        chk("t5_tx_mid", tx, 0);
        chk("t5_busy_mid", busy, 1);
        rst = 1'b1;
        tick();
        chk("t5_tx_rst", tx, 1);
        chk("t5_busy_rst", busy, 0);
        chk("t5_ready_rst", sif.s_ready, 1);
        chk("t5_drop_rst", drop8, 0);
        rst      = 1'b0;
        low_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!tx || busy) low_seen = 1'b1;
        end
        chk("t5_no_resume", low_seen, 0);

        // 6: drop_clr with and without a same-cycle drop
        sif.s_valid = 1'b1;
        sif.s_data  = 8'h3C;
        repeat (6) tick();
        chk("t6_drop8_pre", drop8, 4);
        chk("t6_drop4_pre", drop4, 4);
        drop_clr = 1'b1;
        tick();
        chk("t6_clr_drop8", drop8, 1);
        chk("t6_clr_drop4", drop4, 1);
        sif.s_valid = 1'b0;
        tick();
        chk("t6_clr_only8", drop8, 0);
        chk("t6_clr_only4", drop4, 0);
        drop_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
